// File: rtl/shreg_arb_ctrl_pkg.sv
// Shared definitions for the shift-register arbitration controller.
package shreg_arb_ctrl_pkg;

    // Controller state encoding
    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StLoad  = 2'd1,
        StShift = 2'd2,
        StDone  = 2'd3
    } state_e;

    localparam int unsigned ShiftLenDefault = 4;
    // Wide enough for any shift length up to 15
    localparam int unsigned CntW = 4;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter; 'last' is the index of the requester served last.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    // Single requests win outright; on contention the one not served last wins
    always_comb begin
        gnt = 2'b00;
        unique case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/shreg_arb_ctrl.sv
// Arbitrates two requesters onto one shift register: load, shift SHIFT_LEN times, ack.
module shreg_arb_ctrl
    import shreg_arb_ctrl_pkg::*;
#(
    parameter int unsigned SHIFT_LEN = ShiftLenDefault
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic [3:0] data0,
    input  logic [3:0] data1,
    input  logic [1:0] mode,
    output logic [1:0] gnt,
    output logic [1:0] ack,
    output logic [3:0] pl_data,
    output logic       sl,
    output logic       op,
    output logic       frame,
    output logic       busy
);

    localparam logic [CntW-1:0] CntMax = CntW'(SHIFT_LEN - 1);

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            last_q, last_d;
    logic            sel_q, sel_d;
    logic [3:0]      data_q, data_d;
    logic            mode_q, mode_d;
    logic [1:0]      arb_gnt;

    logic [1:0] gnt_q, gnt_d;
    logic [1:0] ack_q, ack_d;
    logic [3:0] pl_q, pl_d;
    logic       sl_q, sl_d;
    logic       op_q, op_d;
    logic       frame_q, frame_d;
    logic       busy_q, busy_d;

    rr_arb2 u_arb (
        .req  (req),
        .last (last_q),
        .gnt  (arb_gnt)
    );

    // State, counter, latched transfer and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            last_q  <= 1'b1;
            sel_q   <= 1'b0;
            data_q  <= '0;
            mode_q  <= 1'b0;
            gnt_q   <= '0;
            ack_q   <= '0;
            pl_q    <= '0;
            sl_q    <= 1'b0;
            op_q    <= 1'b0;
            frame_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            sel_q   <= sel_d;
            data_q  <= data_d;
            mode_q  <= mode_d;
            gnt_q   <= gnt_d;
            ack_q   <= ack_d;
            pl_q    <= pl_d;
            sl_q    <= sl_d;
            op_q    <= op_d;
            frame_q <= frame_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state logic; inputs are only sampled in idle
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        sel_d   = sel_q;
        data_d  = data_q;
        mode_d  = mode_q;
        unique case (state_q)
            StIdle: begin
                if (|req) begin
                    state_d = StLoad;
                    sel_d   = arb_gnt[1];
                    data_d  = arb_gnt[1] ? data1 : data0;
                    mode_d  = mode[arb_gnt[1]];
                end
            end
            StLoad: begin
                state_d = StShift;
                cnt_d   = '0;
            end
            StShift: begin
                if (cnt_q == CntMax) begin
                    state_d = StDone;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
                last_d  = sel_q;
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs decoded from the next state so the registered copies line up with state_q
    always_comb begin
        logic [1:0] sel_oh;
        sel_oh  = sel_d ? 2'b10 : 2'b01;
        busy_d  = (state_d != StIdle);
        gnt_d   = busy_d ? sel_oh : 2'b00;
        ack_d   = (state_d == StDone) ? sel_oh : 2'b00;
        pl_d    = busy_d ? data_d : 4'b0000;
        op_d    = busy_d & mode_d;
        sl_d    = (state_d == StLoad);
        frame_d = (state_d == StShift);
    end

    assign gnt     = gnt_q;
    assign ack     = ack_q;
    assign pl_data = pl_q;
    assign sl      = sl_q;
    assign op      = op_q;
    assign frame   = frame_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_shreg_arb_ctrl.sv
// Self-checking bench: two instances (SHIFT_LEN=4 and SHIFT_LEN=1) against a transfer-level model.
module tb_shreg_arb_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] req = 2'b00;
    logic [3:0] data0 = 4'h0;
    logic [3:0] data1 = 4'h0;
    logic [1:0] mode = 2'b00;

    logic [1:0] gnt4, ack4, gnt1, ack1;
    logic [3:0] pl4, pl1;
    logic       sl4, op4, fr4, busy4, sl1, op1, fr1, busy1;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    shreg_arb_ctrl #(.SHIFT_LEN(4)) dut (
        .clk(clk), .rst(rst), .req(req), .data0(data0), .data1(data1), .mode(mode),
        .gnt(gnt4), .ack(ack4), .pl_data(pl4), .sl(sl4), .op(op4), .frame(fr4), .busy(busy4)
    );

    shreg_arb_ctrl #(.SHIFT_LEN(1)) dut1 (
        .clk(clk), .rst(rst), .req(req), .data0(data0), .data1(data1), .mode(mode),
        .gnt(gnt1), .ack(ack1), .pl_data(pl1), .sl(sl1), .op(op1), .frame(fr1), .busy(busy1)
    );

    // Reference model: position within a transfer (0 = idle, 1 = load, last = done)
    int         lens[2] = '{4, 1};
    int         pos[2];
    logic       last_m[2];
    logic       sel_m[2];
    logic [3:0] dat_m[2];
    logic       md_m[2];

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            pos[k] = 0; last_m[k] = 1'b1; sel_m[k] = 1'b0; dat_m[k] = 4'h0; md_m[k] = 1'b0;
        end
    endtask

    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            if (pos[k] == 0) begin
                if (req != 2'b00) begin
                    sel_m[k] = (req == 2'b11) ? ~last_m[k] : req[1];
                    dat_m[k] = sel_m[k] ? data1 : data0;
                    md_m[k]  = mode[sel_m[k]];
                    pos[k]   = 1;
                end
            end else if (pos[k] == lens[k] + 2) begin
                last_m[k] = sel_m[k];
                pos[k]    = 0;
            end else begin
                pos[k] = pos[k] + 1;
            end
        end
    endtask

    // Packed as {gnt, ack, pl_data, sl, op, frame, busy}
    function automatic logic [11:0] model_out(int k);
        logic       b;
        logic [1:0] oh;
        b  = (pos[k] != 0);
        oh = sel_m[k] ? 2'b10 : 2'b01;
        return {b ? oh : 2'b00, (pos[k] == lens[k] + 2) ? oh : 2'b00, b ? dat_m[k] : 4'h0,
                pos[k] == 1, b & md_m[k], (pos[k] >= 2) && (pos[k] <= lens[k] + 1), b};
    endfunction

    function automatic logic [11:0] act_out(int k);
        if (k == 0) return {gnt4, ack4, pl4, sl4, op4, fr4, busy4};
        return {gnt1, ack1, pl1, sl1, op1, fr1, busy1};
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic check_model(string name);
        check({name, "_len4"}, 32'(act_out(0)), 32'(model_out(0)));
        check({name, "_len1"}, 32'(act_out(1)), 32'(model_out(1)));
    endtask

    task automatic step(string name);
        @(posedge clk);
        if (!rst) model_edge();
        #1;
        check_model(name);
    endtask

    task automatic do_reset();
        req = 2'b00;
        @(negedge clk);
        rst = 1'b1;
        #1;
        model_reset();
        check_model("reset_immediate");
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    typedef struct {
        logic [1:0]  req;
        logic [3:0]  d0;
        logic [3:0]  d1;
        logic [1:0]  mode;
        logic [11:0] exp4;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int loads[$];
        logic [1:0] gnts[$];
        int frames, busy_cnt, ack_at;
        logic found;

        // Single transfer, request dropped and data0 changed mid-shift
        vecs[0] = '{2'b01, 4'b1011, 4'h0, 2'b01, 12'b01_00_1011_1_1_0_1};
        vecs[1] = '{2'b01, 4'b1011, 4'h0, 2'b01, 12'b01_00_1011_0_1_1_1};
        vecs[2] = '{2'b00, 4'b0000, 4'h0, 2'b01, 12'b01_00_1011_0_1_1_1};
        vecs[3] = '{2'b00, 4'b0000, 4'h0, 2'b01, 12'b01_00_1011_0_1_1_1};
        vecs[4] = '{2'b00, 4'b0000, 4'h0, 2'b01, 12'b01_00_1011_0_1_1_1};
        vecs[5] = '{2'b00, 4'b0000, 4'h0, 2'b01, 12'b01_01_1011_0_1_0_1};
        vecs[6] = '{2'b00, 4'b0000, 4'h0, 2'b00, 12'b00_00_0000_0_0_0_0};

        model_reset();
        #1;
        check_model("reset_initial");
        do_reset();

        for (int i = 0; i < 7; i++) begin
            req = vecs[i].req; data0 = vecs[i].d0; data1 = vecs[i].d1; mode = vecs[i].mode;
            step("vec");
            check($sformatf("vec%0d", i), 32'(act_out(0)), 32'(vecs[i].exp4));
        end

        // Contention after reset: grants alternate 01, 10, 01 with 7-cycle spacing
        do_reset();
        req = 2'b11; data0 = 4'h5; data1 = 4'hA; mode = 2'b10;
        for (int c = 1; c <= 21; c++) begin
            step("contend");
            if (sl4) begin
                loads.push_back(c);
                gnts.push_back(gnt4);
            end
        end
        check("contend_loads", 32'(loads.size()), 32'd3);
        if (loads.size() == 3) begin
            check("contend_g0", 32'(gnts[0]), 32'b01);
            check("contend_g1", 32'(gnts[1]), 32'b10);
            check("contend_g2", 32'(gnts[2]), 32'b01);
            check("contend_gap", 32'(loads[1] - loads[0]), 32'd7);
        end

        // Reset during the third shift cycle
        do_reset();
        req = 2'b01; data0 = 4'h9; mode = 2'b01;
        frames = 0;
        found  = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            step("pre_rst");
            if (fr4) frames++;
            if (frames == 3) found = 1'b1;
        end
        check("bit2_reached", 32'(found), 32'd1);
        rst = 1'b1;
        #1;
        model_reset();
        check("rst_mid_outputs", 32'(act_out(0)), 32'd0);
        req = 2'b00;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int c = 0; c < 8; c++) begin
            step("post_rst");
            check("post_rst_no_ack", 32'(ack4), 32'd0);
        end
        req = 2'b11;
        step("post_rst_grant");
        check("post_rst_gnt0", 32'(gnt4), 32'b01);

        // Back-to-back single requester with mode1 = 0
        do_reset();
        req = 2'b10; data1 = 4'h6; mode = 2'b01;
        loads.delete();
        for (int c = 1; c <= 16; c++) begin
            step("b2b");
            if (sl4) loads.push_back(c);
            if (busy4 && op4) check("b2b_op", 32'(op4), 32'd0);
        end
        check("b2b_loads", 32'(loads.size() >= 2), 32'd1);
        if (loads.size() >= 2) check("b2b_gap", 32'(loads[1] - loads[0]), 32'd7);

        // SHIFT_LEN=1: one frame cycle, ack on the third busy cycle
        do_reset();
        req = 2'b01; data0 = 4'h3;
        frames = 0; busy_cnt = 0; ack_at = 0;
        for (int c = 0; c < 6; c++) begin
            step("len1");
            req = 2'b00;
            if (busy1) busy_cnt++;
            if (fr1) frames++;
            if (ack1 == 2'b01 && ack_at == 0) ack_at = busy_cnt;
        end
        check("len1_frames", 32'(frames), 32'd1);
        check("len1_ack_cycle", 32'(ack_at), 32'd3);

        // Randomized traffic against the model
        do_reset();
        for (int c = 0; c < 400; c++) begin
            req   = 2'($urandom_range(0, 3));
            data0 = 4'($urandom);
            data1 = 4'($urandom);
            mode  = 2'($urandom);
            step("rand");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/shreg_arb_ctrl.md
SHREG_ARB_CTRL -- requirements
Module: shreg_arb_ctrl

Interface
REQ-001 The block SHALL have parameter SHIFT_LEN, default 4, meaning the number of shift cycles per transfer (legal range 1..15).
REQ-002 The block SHALL have port clk, input, 1, the single rising-edge clock.
REQ-003 The block SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 The block SHALL have port req, input, 2, per-requester transfer request, bit i belonging to requester i.
REQ-005 The block SHALL have port data0, input, 4, the parallel word of requester 0.
REQ-006 The block SHALL have port data1, input, 4, the parallel word of requester 1.
REQ-007 The block SHALL have port mode, input, 2, per-requester output-path select, bit i belonging to requester i.
REQ-008 The block SHALL have port gnt, output, 2, one-hot grant, held from LOAD through DONE.
REQ-009 The block SHALL have port ack, output, 2, one-cycle completion pulse to the granted requester.
REQ-010 The block SHALL have port pl_data, output, 4, the parallel word driven to the shift register.
REQ-011 The block SHALL have port sl, output, 1, shift-register select: 1 = parallel load, 0 = shift.
REQ-012 The block SHALL have port op, output, 1, shift-register output-path select.
REQ-013 The block SHALL have port frame, output, 1, high during each shift cycle.
REQ-014 The block SHALL have port busy, output, 1, high in every state except IDLE.

Function
REQ-015 The FSM SHALL have the states IDLE, LOAD, SHIFT and DONE.
REQ-016 In IDLE with req != 0, the block SHALL grant a requester, latch that requester's data and mode bit, and enter LOAD on the next edge.
REQ-017 Arbitration SHALL be round-robin: when both requests are high, the requester not served last wins; a single request wins immediately.
REQ-018 LOAD SHALL last 1 cycle, with sl=1 and pl_data equal to the latched word.
REQ-019 SHIFT SHALL last exactly SHIFT_LEN cycles, with sl=0 and frame=1, using a bit counter that runs from 0 to SHIFT_LEN-1.
REQ-020 DONE SHALL last 1 cycle, with ack[granted]=1 and the last-served pointer updated to the granted requester, and SHALL return to IDLE.
REQ-021 Total occupancy SHALL be SHIFT_LEN+2 cycles per transfer; the earliest next LOAD SHALL be 1 cycle after DONE, because IDLE lasts at least 1 cycle.
REQ-022 op SHALL equal the latched mode bit from LOAD through DONE and SHALL be 0 in IDLE.
REQ-023 pl_data SHALL hold the latched word from LOAD through DONE and SHALL be 0 in IDLE.
REQ-024 In IDLE: gnt=0, ack=0, sl=0, frame=0, busy=0.
REQ-025 Requests SHALL be sampled only in IDLE; a change to req, data or mode during LOAD, SHIFT or DONE SHALL NOT affect the transfer in progress.
REQ-026 Deassertion of the granted request mid-transfer SHALL NOT abort it; the transfer SHALL complete and ack SHALL still pulse.
REQ-027 A request held high through its ack SHALL be treated as a new request in the following IDLE, subject to round-robin.
REQ-028 All outputs SHALL be registered.

Reset
REQ-029 rst=1 SHALL immediately force state=IDLE, bit counter=0 and last-served pointer=1, so that requester 0 wins the first contention.
REQ-030 rst=1 SHALL immediately force all outputs to 0, including outputs asserted mid-transfer.
REQ-031 A reset asserted mid-transfer SHALL discard that transfer with no ack.
REQ-032 After rst deasserts, the first grant SHALL occur no earlier than the first rising edge.

Structure
REQ-033 A shared package SHALL hold the state encoding (IDLE=0, LOAD=1, SHIFT=2, DONE=3) and the default SHIFT_LEN constant.
REQ-034 The round-robin arbiter SHALL be one sub-module, rr_arb2, with inputs req and last, and output a one-hot grant.

Verification
REQ-035 Single request: req=01, data0=1011, mode0=1 -> gnt=01 for 6 cycles; LOAD cycle has sl=1, pl_data=1011, op=1; frame=1 for 4 cycles; ack=01 on cycle 6; busy=0 on cycle 7.
REQ-036 Contention after reset: req=11 held -> grants alternate 01,10,01, each transfer 6 cycles with 1 IDLE cycle between transfers.
REQ-037 Mid-transfer change: data0 changes from 1011 to 0000 and req0 drops during SHIFT -> pl_data stays 1011; ack=01 still pulses.
REQ-038 Reset in SHIFT: rst pulsed at bit 2 -> all outputs are 0 immediately, no ack follows, and the next req=11 grants requester 0.
REQ-039 Back-to-back single requester: req=10 held, mode1=0 -> op=0 throughout; second LOAD occurs exactly 7 cycles after the first LOAD.
REQ-040 SHIFT_LEN=1: req=01 -> frame is high for 1 cycle and ack arrives on the 3rd busy cycle.
